// File: rtl/input_loader.sv
// ---------------------------------------------------------------------------
// input_loader
//   Front-end stage of the MLP datapath. Takes one frame of 8-bit unsigned
//   pixels over a valid/ready stream, converts each one to the 16-bit signed
//   neuron format, and writes it into the input region of neuron memory.
//   When the last pixel of the frame has been written, load_done_o pulses
//   once. That pulse launches the control unit.
//
// Parameters
//   NUM_INPUTS  pixels per frame (1 .. 2**ADDR_W - BASE_ADDR)
//   ADDR_W      neuron memory address width
//   BASE_ADDR   neuron address that receives pixel 0
//   SHIFT       left shift applied during conversion (0..8)
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   start_i      begin a frame (honoured only in IDLE)
//   pix_valid_i  pix_data_i carries a pixel this cycle
//   pix_data_i   unsigned 8-bit pixel
//   pix_ready_o  loader accepts a pixel this cycle (high exactly in LOAD)
//   wr_en_o      neuron memory write strobe (one cycle after each handshake)
//   wr_addr_o    neuron memory write address
//   wr_data_o    converted, saturated neuron value
//   busy_o       frame in progress (LOAD and DRAIN)
//   load_done_o  one-cycle pulse once the frame is fully written
// ---------------------------------------------------------------------------
module input_loader #(
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_W     = 12,
  parameter int BASE_ADDR  = 0,
  parameter int SHIFT      = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              pix_valid_i,
  input  logic [7:0]        pix_data_i,
  output logic              pix_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              busy_o,
  output logic              load_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              pix_ready_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [15:0]       wr_data_d;
  logic              busy_d;
  logic              load_done_d;

  logic              handshake;
  logic [16:0]       shifted;
  logic [15:0]       converted;

  // pix_ready_o is high exactly in LOAD, so the registered state stands in
  // for it here and avoids a path through the output flop.
  assign handshake = (state_q == LOAD) && pix_valid_i;

  // The shift is done at 17 bits so that 255 << 8 cannot wrap. Anything
  // above the largest positive 16-bit signed value saturates, which keeps
  // every neuron input non-negative.
  assign shifted   = {9'b0, pix_data_i} << SHIFT;
  assign converted = (shifted > 17'h07FFF) ? 16'h7FFF : shifted[15:0];

  // State register, frame index and output registers. Every output is a
  // flop, and reset clears all of them along with the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pix_ready_o <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      load_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pix_ready_o <= pix_ready_d;
      wr_en_o     <= wr_en_d;
      wr_addr_o   <= wr_addr_d;
      wr_data_o   <= wr_data_d;
      busy_o      <= busy_d;
      load_done_o <= load_done_d;
    end
  end

  // Next-state logic. start_i is only looked at in IDLE, so a start pulse
  // in any other state, DONE included, is dropped. Stalls in LOAD hold both
  // the state and the index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          idx_d = idx_q + ADDR_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The values are computed from the next state so that the
  // registered outputs line up with the state they describe. The write is
  // registered one cycle behind its handshake, so the final write lands in
  // DRAIN and can never coincide with the load_done pulse in DONE.
  always_comb begin
    pix_ready_d = (state_d == LOAD);
    busy_d      = (state_d == LOAD) || (state_d == DRAIN);
    load_done_d = (state_d == DONE);
    wr_en_d     = handshake;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    if (handshake) begin
      wr_addr_d = BASE + idx_q;
      wr_data_d = converted;
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// Scoreboard bench for input_loader. Two instances share the clock and
// reset: dut 0 uses NUM_INPUTS=4, SHIFT=0, BASE_ADDR=0, and dut 1 uses
// NUM_INPUTS=3, SHIFT=8, BASE_ADDR=5. The stimulus pushes the hand-computed
// writes and load_done pulses it expects into queues. A negedge monitor pops
// and compares them whenever a DUT asserts wr_en or load_done.
module tb_input_loader;

  typedef struct {
    int d;
    int cyc;
    int addr;
    int data;
  } wrExp_t;

  typedef struct {
    int d;
    int cyc;
  } doneExp_t;

  logic        clock;
  logic        reset;
  logic        start     [2];
  logic        pixValid  [2];
  logic [7:0]  pixData   [2];
  logic        pixReady  [2];
  logic        wrEn      [2];
  logic [11:0] wrAddr    [2];
  logic [15:0] wrData    [2];
  logic        busy      [2];
  logic        loadDone  [2];

  wrExp_t   expQ[$];
  doneExp_t doneQ[$];
  int       cyc = 0;
  int       checkCount = 0;
  int       passCount = 0;

  input_loader #(.NUM_INPUTS(4), .ADDR_W(12), .BASE_ADDR(0), .SHIFT(0)) dut0 (
    .clk_i(clock), .reset_i(reset), .start_i(start[0]),
    .pix_valid_i(pixValid[0]), .pix_data_i(pixData[0]),
    .pix_ready_o(pixReady[0]), .wr_en_o(wrEn[0]), .wr_addr_o(wrAddr[0]),
    .wr_data_o(wrData[0]), .busy_o(busy[0]), .load_done_o(loadDone[0])
  );

  input_loader #(.NUM_INPUTS(3), .ADDR_W(12), .BASE_ADDR(5), .SHIFT(8)) dut1 (
    .clk_i(clock), .reset_i(reset), .start_i(start[1]),
    .pix_valid_i(pixValid[1]), .pix_data_i(pixData[1]),
    .pix_ready_o(pixReady[1]), .wr_en_o(wrEn[1]), .wr_addr_o(wrAddr[1]),
    .wr_data_o(wrData[1]), .busy_o(busy[1]), .load_done_o(loadDone[1])
  );

  // Free-running clock and a cycle counter used to time-stamp expectations.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Monitor: every write or load_done must match the head of its queue,
  // including the exact cycle it was predicted for.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (wrEn[d] === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWrite", int'(wrAddr[d]), -1);
        end else begin
          wrExp_t e;
          e = expQ.pop_front();
          checkOutput("wrDut", d, e.d);
          checkOutput("wrCycle", cyc, e.cyc);
          checkOutput("wrAddr", int'(wrAddr[d]), e.addr);
          checkOutput("wrData", int'(wrData[d]), e.data);
        end
      end
      if (loadDone[d] === 1'b1) begin
        checkOutput("doneWithWrite", int'(wrEn[d]), 0);
        if (doneQ.size() == 0) begin
          checkOutput("unexpectedDone", cyc, -1);
        end else begin
          doneExp_t e;
          e = doneQ.pop_front();
          checkOutput("doneDut", d, e.d);
          checkOutput("doneCycle", cyc, e.cyc);
        end
      end
    end
  end

  // Pulse start in IDLE, then confirm LOAD is entered (ready and busy high).
  task automatic startFrame(input int d);
    start[d] = 1'b1;
    @(posedge clock); #1;
    start[d] = 1'b0;
    @(negedge clock);
    checkOutput("loadReady", int'(pixReady[d]), 1);
    checkOutput("loadBusy", int'(busy[d]), 1);
    @(posedge clock); #1;
  endtask

  // Present one pixel for one cycle and predict the write it must cause.
  task automatic applyStimulus(input int d, input int pix, input int addr,
                               input int data, input bit last);
    pixValid[d] = 1'b1;
    pixData[d]  = 8'(pix);
    @(negedge clock);
    checkOutput("hsReady", int'(pixReady[d]), 1);
    expQ.push_back('{d, cyc + 1, addr, data});
    if (last) doneQ.push_back('{d, cyc + 2});
    @(posedge clock); #1;
    pixValid[d] = 1'b0;
  endtask

  // Stall cycles in LOAD: ready must stay up and nothing is written.
  task automatic stallCycles(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput("stallReady", int'(pixReady[d]), 1);
      @(posedge clock); #1;
    end
  endtask

  // Walk DRAIN, DONE and back to IDLE. Optionally keep pix_valid high
  // throughout, and always pulse start in the DONE cycle; both must be ignored.
  task automatic finishFrame(input int d, input bit holdValid);
    if (holdValid) begin
      pixValid[d] = 1'b1;
      pixData[d]  = 8'd99;
    end
    @(negedge clock);
    checkOutput("drainReady", int'(pixReady[d]), 0);
    checkOutput("drainBusy", int'(busy[d]), 1);
    @(posedge clock); #1;
    start[d] = 1'b1;
    @(negedge clock);
    checkOutput("doneReady", int'(pixReady[d]), 0);
    checkOutput("doneBusy", int'(busy[d]), 0);
    @(posedge clock); #1;
    start[d] = 1'b0;
    @(negedge clock);
    checkOutput("idleReady", int'(pixReady[d]), 0);
    checkOutput("idleBusy", int'(busy[d]), 0);
    @(posedge clock); #1;
    pixValid[d] = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d]    = 1'b0;
      pixValid[d] = 1'b0;
      pixData[d]  = 8'd0;
    end

    // Reset state: every output low.
    @(posedge clock); #1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstReady", int'(pixReady[d]), 0);
      checkOutput("rstWrEn", int'(wrEn[d]), 0);
      checkOutput("rstAddr", int'(wrAddr[d]), 0);
      checkOutput("rstData", int'(wrData[d]), 0);
      checkOutput("rstBusy", int'(busy[d]), 0);
      checkOutput("rstDone", int'(loadDone[d]), 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    // pix_valid in IDLE: not accepted, no state change.
    pixValid[0] = 1'b1;
    pixData[0]  = 8'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("idleValidReady", int'(pixReady[0]), 0);
      checkOutput("idleValidBusy", int'(busy[0]), 0);
      @(posedge clock); #1;
    end
    pixValid[0] = 1'b0;

    // Back-to-back frame 0,1,128,255 with SHIFT=0.
    startFrame(0);
    applyStimulus(0, 0,   0, 0,   1'b0);
    applyStimulus(0, 1,   1, 1,   1'b0);
    applyStimulus(0, 128, 2, 128, 1'b0);
    applyStimulus(0, 255, 3, 255, 1'b1);
    finishFrame(0, 1'b0);

    // Gapped frame, start pulsed mid-frame, valid held after the last pixel.
    startFrame(0);
    applyStimulus(0, 10, 0, 10, 1'b0);
    stallCycles(0, 2);
    start[0] = 1'b1;
    applyStimulus(0, 20, 1, 20, 1'b0);
    start[0] = 1'b0;
    stallCycles(0, 2);
    applyStimulus(0, 30, 2, 30, 1'b0);
    stallCycles(0, 1);
    applyStimulus(0, 40, 3, 40, 1'b1);
    finishFrame(0, 1'b1);

    // Reset after 2 of 4 pixels, then a full frame from address 0.
    startFrame(0);
    applyStimulus(0, 5, 0, 5, 1'b0);
    applyStimulus(0, 6, 1, 6, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("abortReady", int'(pixReady[0]), 0);
    checkOutput("abortBusy", int'(busy[0]), 0);
    checkOutput("abortWrEn", int'(wrEn[0]), 0);
    checkOutput("abortDone", int'(loadDone[0]), 0);
    @(posedge clock); #1;
    startFrame(0);
    applyStimulus(0, 50, 0, 50, 1'b0);
    applyStimulus(0, 60, 1, 60, 1'b0);
    applyStimulus(0, 70, 2, 70, 1'b0);
    applyStimulus(0, 80, 3, 80, 1'b1);
    finishFrame(0, 1'b0);

    // SHIFT=8 conversion and saturation, base address 5.
    startFrame(1);
    applyStimulus(1, 1,   5, 16'h0100, 1'b0);
    applyStimulus(1, 127, 6, 16'h7F00, 1'b0);
    applyStimulus(1, 128, 7, 16'h7FFF, 1'b1);
    finishFrame(1, 1'b0);

    // Everything predicted must have been seen.
    repeat (5) @(posedge clock);
    @(negedge clock);
    checkOutput("pendingWrites", expQ.size(), 0);
    checkOutput("pendingDones", doneQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
